// File: rtl/connect_k_game.sv
// connect_k_game: N x N board, K-in-a-row two-player engine with a 4-cycle directional win scan.
// Define CONNECT_TIMEOUT_EN to enable the per-move forfeit timeout.
module connect_k_game #(
    parameter int N = 5,
    parameter int K = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    localparam int RW = $clog2(N),
    localparam int CW = $clog2(N * N + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          new_game,
    input  logic          move_valid,
    input  logic [RW-1:0] move_row,
    input  logic [RW-1:0] move_col,
    input  logic          move_player,
    output logic          move_ready,
    output logic          move_ack,
    output logic          move_err,
    output logic [1:0]    err_code,
    output logic          current_turn,
    output logic [1:0]    game_status,
    output logic [CW-1:0] move_count,
    output logic          timeout
);
    localparam int CELLS = N * N;
    localparam int IW = $clog2(CELLS);
    localparam logic [RW:0] SIDE = (RW + 1)'(N);

    localparam logic [1:0] CELL_EMPTY = 2'b10;
    localparam logic [1:0] CELL_A     = 2'b01;
    localparam logic [1:0] CELL_B     = 2'b00;

    localparam logic [1:0] ST_DRAW  = 2'b00;
    localparam logic [1:0] ST_A_WIN = 2'b01;
    localparam logic [1:0] ST_B_WIN = 2'b10;
    localparam logic [1:0] ST_PLAY  = 2'b11;

    localparam logic [1:0] ERR_OVER  = 2'b00;
    localparam logic [1:0] ERR_OCC   = 2'b01;
    localparam logic [1:0] ERR_RANGE = 2'b10;
    localparam logic [1:0] ERR_TURN  = 2'b11;

    if (N < 3 || N > 8 || K < 3 || K > N || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("connect_k_game: parameter out of range");
    end

    typedef enum logic [1:0] {PLAY = 2'b00, CHECK = 2'b01, OVER = 2'b10} state_t;

    state_t        state, next_state;
    logic [1:0]    board [CELLS];
    logic [1:0]    dir;
    logic          win_seen;
    logic [RW-1:0] row_q, col_q;
    logic          player_q;
    logic [1:0]    player_cell;

    logic          in_range, occupied, evaluate, accept, reject;
    logic [IW-1:0] move_addr;
    logic [1:0]    reject_code;
    logic          dir_win, line_found, board_full;
    logic          timeout_hit;

    assign move_ready  = (state == PLAY);
    assign in_range    = ({1'b0, move_row} < SIDE) && ({1'b0, move_col} < SIDE);
    assign move_addr   = IW'(int'(move_row) * N + int'(move_col));
    assign occupied    = (board[move_addr] != CELL_EMPTY);
    assign evaluate    = move_valid && !new_game && (state == PLAY || state == OVER);
    assign accept      = evaluate && (state == PLAY) && in_range &&
                         (move_player == current_turn) && !occupied;
    assign reject      = evaluate && !accept;
    assign player_cell = player_q ? CELL_A : CELL_B;
    assign line_found  = win_seen || dir_win;
    assign board_full  = (move_count == CW'(CELLS));

    always_comb begin
        reject_code = ERR_OCC;
        if (state == OVER)
            reject_code = ERR_OVER;
        else if (!in_range)
            reject_code = ERR_RANGE;
        else if (move_player != current_turn)
            reject_code = ERR_TURN;
    end

    // Walk outward from the placed cell both ways along the current direction; edges stop the walk.
    always_comb begin
        int  dr, dc, r, c, run_len;
        logic go;
        dr = 0;
        dc = 1;
        case (dir)
            2'd0:    begin dr = 0; dc = 1;  end
            2'd1:    begin dr = 1; dc = 0;  end
            2'd2:    begin dr = 1; dc = 1;  end
            default: begin dr = 1; dc = -1; end
        endcase
        run_len = 1;
        r = 0;
        c = 0;
        go = 1'b1;
        for (int i = 1; i < K; i++) begin
            r = int'(row_q) + i * dr;
            c = int'(col_q) + i * dc;
            if (go && r >= 0 && r < N && c >= 0 && c < N && board[IW'(r * N + c)] == player_cell)
                run_len = run_len + 1;
            else
                go = 1'b0;
        end
        go = 1'b1;
        for (int i = 1; i < K; i++) begin
            r = int'(row_q) - i * dr;
            c = int'(col_q) - i * dc;
            if (go && r >= 0 && r < N && c >= 0 && c < N && board[IW'(r * N + c)] == player_cell)
                run_len = run_len + 1;
            else
                go = 1'b0;
        end
        dir_win = (run_len >= K);
    end

`ifdef CONNECT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0] idle_cnt;

    assign timeout_hit = (state == PLAY) && !accept && !new_game &&
                         (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            idle_cnt <= '0;
        else if (new_game || accept || timeout_hit)
            idle_cnt <= '0;
        else if (state == PLAY)
            idle_cnt <= idle_cnt + 1'b1;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= PLAY;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            PLAY: begin
                if (accept)
                    next_state = CHECK;
                else if (timeout_hit)
                    next_state = OVER;
            end
            CHECK: begin
                if (dir == 2'd3)
                    next_state = (line_found || board_full) ? OVER : PLAY;
            end
            default: next_state = OVER;
        endcase
        if (new_game)
            next_state = PLAY;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CELLS; i++)
                board[i] <= CELL_EMPTY;
            move_ack     <= 1'b0;
            move_err     <= 1'b0;
            err_code     <= ERR_OVER;
            current_turn <= 1'b1;
            game_status  <= ST_PLAY;
            move_count   <= '0;
            timeout      <= 1'b0;
            dir          <= 2'd0;
            win_seen     <= 1'b0;
            row_q        <= '0;
            col_q        <= '0;
            player_q     <= 1'b0;
        end else begin
            move_ack <= 1'b0;
            move_err <= 1'b0;
            if (new_game) begin
                for (int i = 0; i < CELLS; i++)
                    board[i] <= CELL_EMPTY;
                err_code     <= ERR_OVER;
                current_turn <= 1'b1;
                game_status  <= ST_PLAY;
                move_count   <= '0;
                timeout      <= 1'b0;
                dir          <= 2'd0;
                win_seen     <= 1'b0;
            end else begin
                if (accept) begin
                    board[move_addr] <= move_player ? CELL_A : CELL_B;
                    move_count       <= move_count + 1'b1;
                    row_q            <= move_row;
                    col_q            <= move_col;
                    player_q         <= move_player;
                    dir              <= 2'd0;
                    win_seen         <= 1'b0;
                    move_ack         <= 1'b1;
                end
                if (reject) begin
                    move_err <= 1'b1;
                    err_code <= reject_code;
                end
                // A completed line outranks a full board, and a win keeps the winner as current_turn.
                if (state == CHECK) begin
                    dir <= dir + 2'd1;
                    if (dir_win)
                        win_seen <= 1'b1;
                    if (dir == 2'd3) begin
                        if (line_found)
                            game_status <= player_q ? ST_A_WIN : ST_B_WIN;
                        else if (board_full)
                            game_status <= ST_DRAW;
                        else
                            current_turn <= ~current_turn;
                    end
                end
                if (timeout_hit) begin
                    game_status <= current_turn ? ST_B_WIN : ST_A_WIN;
                    timeout     <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_connect_k_game.sv
// Scoreboard bench for connect_k_game (N=5, K=4): a whole-board reference model predicts
// every ack/err response, and a monitor process checks them as the DUT presents them.
module tb_connect_k_game;
    localparam int N = 5;
    localparam int K = 4;
    localparam int RW = $clog2(N);
    localparam int CW = $clog2(N * N + 1);
    localparam int TO = 40;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          new_game = 1'b0;
    logic          move_valid = 1'b0;
    logic [RW-1:0] move_row = '0;
    logic [RW-1:0] move_col = '0;
    logic          move_player = 1'b0;
    logic          move_ready, move_ack, move_err, current_turn, timeout;
    logic [1:0]    err_code, game_status;
    logic [CW-1:0] move_count;

    connect_k_game #(.N(N), .K(K), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .new_game(new_game), .move_valid(move_valid),
        .move_row(move_row), .move_col(move_col), .move_player(move_player),
        .move_ready(move_ready), .move_ack(move_ack), .move_err(move_err),
        .err_code(err_code), .current_turn(current_turn), .game_status(game_status),
        .move_count(move_count), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_err;
        int code;
        int count;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    // Reference model: 0 empty, 1 A, 2 B; status 0 draw, 1 A wins, 2 B wins, 3 in progress.
    int mb[N*N];
    bit m_turn;
    int m_status, m_count, m_code;
    bit m_over, m_timeout;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void modelClear();
        for (int i = 0; i < N * N; i++) mb[i] = 0;
        m_turn = 1'b1;
        m_status = 3;
        m_count = 0;
        m_code = 0;
        m_over = 1'b0;
        m_timeout = 1'b0;
    endfunction

    function automatic bit lineWin(input int p);
        int dr[4] = '{0, 1, 1, 1};
        int dc[4] = '{1, 0, 1, -1};
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                for (int d = 0; d < 4; d++) begin
                    bit ok = 1'b1;
                    for (int i = 0; i < K; i++) begin
                        int rr = r + i * dr[d];
                        int cc = c + i * dc[d];
                        if (rr < 0 || rr >= N || cc < 0 || cc >= N) ok = 1'b0;
                        else if (mb[rr * N + cc] != p) ok = 1'b0;
                    end
                    if (ok) return 1'b1;
                end
        return 1'b0;
    endfunction

    task automatic checkOutput(input string name);
        check({name, ".status"}, int'(game_status), m_status);
        check({name, ".turn"}, int'(current_turn), int'(m_turn));
        check({name, ".count"}, int'(move_count), m_count);
        check({name, ".ready"}, int'(move_ready), int'(!m_over));
        check({name, ".timeout"}, int'(timeout), int'(m_timeout));
        check({name, ".err_code"}, int'(err_code), m_code);
    endtask

    // Issues one move at a negedge; the expected response goes to the scoreboard before the edge.
    task automatic applyStimulus(input int row, input int col, input bit player, input bit poke);
        exp_t e;
        bit   acc = 1'b0;
        e.is_err = 1'b1;
        e.code = 0;
        if (m_over) e.code = 0;
        else if (row >= N || col >= N) e.code = 2;
        else if (player != m_turn) e.code = 3;
        else if (mb[row * N + col] != 0) e.code = 1;
        else begin
            acc = 1'b1;
            e.is_err = 1'b0;
        end
        e.count = acc ? m_count + 1 : m_count;
        @(negedge clk);
        move_valid = 1'b1;
        move_row = RW'(row);
        move_col = RW'(col);
        move_player = player;
        sb.push_back(e);
        @(negedge clk);
        if (acc) begin
            int p = player ? 1 : 2;
            mb[row * N + col] = p;
            m_count++;
            if (lineWin(p)) begin
                m_status = p;
                m_over = 1'b1;
            end else if (m_count == N * N) begin
                m_status = 0;
                m_over = 1'b1;
            end else begin
                m_turn = !m_turn;
            end
            move_valid = poke;
            move_row = RW'($urandom_range(0, 7));
            move_col = RW'($urandom_range(0, 7));
            move_player = 1'($urandom_range(0, 1));
            @(negedge clk);
            move_valid = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            checkOutput("after_scan");
        end else begin
            move_valid = 1'b0;
            m_code = e.code;
            checkOutput("after_reject");
        end
    endtask

    task automatic playPair(input int a[$], input int b[$]);
        for (int i = 0; i < a.size(); i++) begin
            if (m_over) break;
            applyStimulus(a[i] / 10, a[i] % 10, 1'b1, 1'($urandom_range(0, 1)));
            if (m_over || i >= b.size()) continue;
            applyStimulus(b[i] / 10, b[i] % 10, 1'b0, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic newGame(input bit with_move);
        @(negedge clk);
        new_game = 1'b1;
        move_valid = with_move;
        move_row = RW'(2);
        move_col = RW'(2);
        move_player = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        move_valid = 1'b0;
        modelClear();
        checkOutput("new_game");
    endtask

    task automatic doReset(input string name);
        reset = 1'b1;
        #1;
        modelClear();
        sb.delete();
        checkOutput(name);
        check({name, ".ack"}, int'(move_ack), 0);
        check({name, ".err"}, int'(move_err), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: every ack/err pulse must match the oldest outstanding prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!reset && (move_ack || move_err)) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_resp: ack=%0d err=%0d with no pending move",
                             move_ack, move_err);
                end else begin
                    e = sb.pop_front();
                    check("resp.is_err", int'(move_err), int'(e.is_err));
                    check("resp.ack", int'(move_ack), int'(!e.is_err));
                    if (e.is_err) check("resp.code", int'(err_code), e.code);
                    check("resp.count", int'(move_count), e.count);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int qa[$];
        int qb[$];
        modelClear();
        @(negedge clk);
        doReset("reset");

        // A takes row 0, B row 4; A completes four on its fourth move.
        qa = '{0, 1, 2, 3};
        qb = '{40, 41, 42};
        playPair(qa, qb);
        applyStimulus(3, 3, 1'b0, 1'b0);
        applyStimulus(1, 1, 1'b1, 1'b0);

        newGame(1'b0);
        applyStimulus(0, 0, 1'b0, 1'b0);
        applyStimulus(5, 0, 1'b1, 1'b0);
        applyStimulus(0, 6, 1'b1, 1'b0);
        applyStimulus(2, 2, 1'b1, 1'b0);
        applyStimulus(2, 2, 1'b0, 1'b0);
        applyStimulus(1, 1, 1'b1, 1'b0);

        // Flat indices 3..6 for A must not wrap into a win; B then takes the anti-diagonal.
        newGame(1'b0);
        qa = '{3, 4, 10, 11};
        qb = '{14, 23, 32, 41};
        playPair(qa, qb);

        // Full board with no line anywhere: draw.
        newGame(1'b0);
        qa = '{0, 2, 4, 10, 12, 14, 21, 23, 31, 33, 40, 42, 44};
        qb = '{1, 3, 11, 13, 20, 22, 24, 30, 32, 34, 41, 43};
        playPair(qa, qb);

        // Full board whose last stone completes column 0 for A: win, not draw.
        newGame(1'b0);
        qa = '{0, 2, 4, 10, 12, 14, 20, 21, 23, 31, 33, 42, 30};
        qb = '{1, 3, 11, 13, 22, 24, 32, 34, 40, 41, 43, 44};
        playPair(qa, qb);

        // Reset in the second scan cycle aborts the scan.
        newGame(1'b0);
        @(negedge clk);
        move_valid = 1'b1;
        move_row = RW'(1);
        move_col = RW'(1);
        move_player = 1'b1;
        sb.push_back('{is_err: 1'b0, code: 0, count: 1});
        @(negedge clk);
        move_valid = 1'b0;
        @(posedge clk);
        #2;
        doReset("reset_mid_check");

        // new_game drops a simultaneous move; the cell must still be free afterwards.
        newGame(1'b1);
        applyStimulus(2, 2, 1'b1, 1'b0);

        newGame(1'b0);
`ifdef CONNECT_TIMEOUT_EN
        repeat (TO - 1) @(posedge clk);
        #1;
        checkOutput("idle_before_expiry");
        @(posedge clk);
        #1;
        m_status = 2;
        m_over = 1'b1;
        m_timeout = 1'b1;
        checkOutput("forfeit");
        newGame(1'b0);
`else
        repeat (TO + 10) @(posedge clk);
        #1;
        checkOutput("idle_no_timeout");
`endif

        for (int g = 0; g < 12; g++) begin
            newGame(1'b0);
            for (int t = 0; t < 120 && !m_over; t++) begin
                int  r = ($urandom_range(0, 9) == 0) ? int'($urandom_range(N, 7)) : int'($urandom_range(0, N - 1));
                int  c = ($urandom_range(0, 9) == 0) ? int'($urandom_range(N, 7)) : int'($urandom_range(0, N - 1));
                bit  p = ($urandom_range(0, 9) == 0) ? !m_turn : m_turn;
                applyStimulus(r, c, p, 1'($urandom_range(0, 1)));
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            if (m_over) begin
                applyStimulus(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0);
                applyStimulus(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0);
            end
        end

        repeat (4) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
